screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Top-level game-flow controller for the overlay screens. Sequences START -> PLAY -> (PAUSE) -> GAME_OVER -> START,
//  enables the start/game-over overlay drawers, freezes/clears game logic, generates a frame-rate blink,
//  and muxes overlay vs. game RGB into one registered pixel stream for the VGA back end.
// PARAMETERS
//  BLINK_FRAMES      30   frames per blink half-period (blink toggles every BLINK_FRAMES startOfFrame pulses)
//  GO_HOLD_FRAMES    180  frames GAME_OVER is held before a start press is accepted
//  DEBOUNCE_FRAMES   4    consecutive high frame-samples required to register a key press (>=1)
// PORTS
//  clk               in   1   system/pixel clock; single clock domain
//  reset             in   1   synchronous, active-high
//  startOfFrame      in   1   one-clk pulse per frame
//  gameEnded         in   1   level from game logic: lives exhausted
//  key_start         in   1   raw start key level (1 = pressed)
//  key_pause         in   1   raw pause key level (1 = pressed)
//  start_screen_dr   in   1   start overlay drawing request
//  start_screen_RGB  in   12  start overlay colour
//  game_over_dr      in   1   game-over overlay drawing request
//  game_over_RGB     in   12  game-over overlay colour
//  game_RGB          in   12  playfield colour
//  game_enable       out  1   1 only in PLAY; game logic advances only when high
//  new_game          out  1   one-clk pulse: clear score/lives/level
//  start_screen_en   out  1   1 in START
//  game_over_en      out  1   1 in GAME_OVER
//  pause_en          out  1   1 in PAUSE
//  blink             out  1   blink phase, runs in START and GAME_OVER, forced 1 elsewhere
//  RGBout            out  12  registered merged pixel
// BEHAVIOUR
//  - Reset (sync, any state, mid-frame): state=START, counters=0, blink=1, new_game=0, game_enable=0,
//    start_screen_en=1, game_over_en=0, pause_en=0, RGBout=12'h000, debouncers cleared and armed.
//  - Key press: each key sampled only on startOfFrame; press = DEBOUNCE_FRAMES consecutive high samples;
//    press is a one-clk pulse on the clk of the qualifying sample; re-arms only after one low sample.
//  - FSM (all registered; outputs are Moore-decoded from state except new_game):
//    START     : start press -> CLEAR.
//    CLEAR     : new_game=1 for exactly this clk -> PLAY next clk.
//    PLAY      : gameEnded=1 -> GAME_OVER (wins over simultaneous pause press); else pause press -> PAUSE.
//    PAUSE     : pause press -> PLAY; gameEnded and start press ignored.
//    GAME_OVER : hold_cnt counts startOfFrame up to GO_HOLD_FRAMES (saturates); start press with
//                hold_cnt==GO_HOLD_FRAMES -> CLEAR; earlier presses discarded (not queued).
//  - hold_cnt cleared on every entry to GAME_OVER. Width $clog2(GO_HOLD_FRAMES+1).
//  - blink: blink_cnt counts startOfFrame in START/GAME_OVER; at BLINK_FRAMES-1 wraps to 0 and blink toggles.
//    On any state change blink_cnt=0, blink=1. Width $clog2(BLINK_FRAMES).
//  - RGB merge, 1 clk latency: START & start_screen_dr -> start_screen_RGB; START & !dr -> 12'h000;
//    GAME_OVER & game_over_dr & blink -> game_over_RGB; else GAME_OVER -> game_RGB;
//    PLAY/PAUSE/CLEAR -> game_RGB. Callers delay pixel timing by 1 clk.
//  - startOfFrame and key edge in same clk: the sample uses the current key level.
// STRUCTURE
//  - screen_pkg: enum logic [2:0] {ST_START, ST_CLEAR, ST_PLAY, ST_PAUSE, ST_GAME_OVER} screen_state_t;
//    typedef logic [11:0] rgb_t; constant RGB_BLACK = 12'h000.
//  - Sub-module frame_key_debouncer (#DEBOUNCE_FRAMES; clk, reset, startOfFrame, key -> press),
//    instantiated twice (start, pause). FSM, counters and RGB register in this module.
// TESTING (bench params BLINK_FRAMES=3, GO_HOLD_FRAMES=5, DEBOUNCE_FRAMES=2)
//  1 reset; key_start high 2 frames -> press on 2nd SOF, CLEAR 1 clk with new_game=1, then PLAY, game_enable=1.
//  2 PLAY; key_pause 1 frame high then low -> no transition; 2 frames -> PAUSE, game_enable=0; again -> PLAY.
//  3 PLAY; gameEnded=1 same clk as pause press -> GAME_OVER, pause_en never 1, hold_cnt=0.
//  4 GAME_OVER; start press at frame 3 -> stays; held key ignored until released; press after 5 SOF -> CLEAR.
//  5 START; 6 SOF -> blink 1,1,1->0 at SOF3, ->1 at SOF6; RGBout = start_screen_RGB 1 clk after dr=1, else 000.
//  6 assert reset mid-PAUSE and mid-GAME_OVER -> next clk START, all outputs at reset values, no new_game.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types for the overlay screen sequencer: screen states and the 12-bit pixel type.
package screen_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_CLEAR,
    ST_PLAY,
    ST_PAUSE,
    ST_GAME_OVER
  } screen_state_t;

  typedef logic [11:0] rgb_t;

  localparam rgb_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/frame_key_debouncer.sv
// Frame-rate key debouncer: a press is DEBOUNCE_FRAMES consecutive high samples taken on
// startOfFrame, reported as a single-clock pulse; it re-arms only after a low sample.
module frame_key_debouncer #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [CW-1:0] cnt_q;
  logic          armed_q;

  // The qualifying sample itself produces the pulse, so the FSM reacts on the next edge.
  assign press = startOfFrame & key & armed_q & (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (startOfFrame) begin
      if (!key) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else if (press) begin
        armed_q <= 1'b0;
      end else if (cnt_q != LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller for the overlay screens: sequences start/play/pause/game-over,
// generates the frame-rate blink and registers the merged overlay/game pixel.
//
// state        | meaning
// ST_START     | start overlay shown, waiting for a start press
// ST_CLEAR     | one clock: new_game pulse clears score/lives/level
// ST_PLAY      | game logic running
// ST_PAUSE     | game frozen, waiting for a pause press
// ST_GAME_OVER | game-over overlay; start accepted only after the hold time
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int BLINK_FRAMES    = 30,
  parameter int GO_HOLD_FRAMES  = 180,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        gameEnded,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic        start_screen_dr,
  input  logic [11:0] start_screen_RGB,
  input  logic        game_over_dr,
  input  logic [11:0] game_over_RGB,
  input  logic [11:0] game_RGB,
  output logic        game_enable,
  output logic        new_game,
  output logic        start_screen_en,
  output logic        game_over_en,
  output logic        pause_en,
  output logic        blink,
  output logic [11:0] RGBout
);

  localparam int HW = $clog2(GO_HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(GO_HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  screen_state_t state_q, state_d;
  logic [HW-1:0] hold_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  rgb_t          rgb_q, rgb_d;
  logic          start_press, pause_press, blink_state;

  frame_key_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_start_db (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .key(key_start), .press(start_press)
  );

  frame_key_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_pause_db (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .key(key_pause), .press(pause_press)
  );

  assign blink_state = (state_q == ST_START) || (state_q == ST_GAME_OVER);

  // gameEnded outranks a simultaneous pause press in PLAY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_START:     if (start_press) state_d = ST_CLEAR;
      ST_CLEAR:     state_d = ST_PLAY;
      ST_PLAY:      if (gameEnded) state_d = ST_GAME_OVER;
                    else if (pause_press) state_d = ST_PAUSE;
      ST_PAUSE:     if (pause_press) state_d = ST_PLAY;
      ST_GAME_OVER: if (start_press && hold_cnt_q == HOLD_MAX) state_d = ST_CLEAR;
      default:      state_d = ST_START;
    endcase
  end

  always_comb begin
    rgb_d = game_RGB;
    case (state_q)
      ST_START:     rgb_d = start_screen_dr ? start_screen_RGB : RGB_BLACK;
      ST_GAME_OVER: if (game_over_dr && blink_q) rgb_d = game_over_RGB;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_START;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      rgb_q       <= RGB_BLACK;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      if (state_d != state_q) begin
        hold_cnt_q  <= '0;
        blink_cnt_q <= '0;
        blink_q     <= 1'b1;
      end else if (startOfFrame && blink_state) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
        if (state_q == ST_GAME_OVER && hold_cnt_q != HOLD_MAX)
          hold_cnt_q <= hold_cnt_q + HW'(1);
      end
    end
  end

  assign game_enable     = (state_q == ST_PLAY);
  assign new_game        = (state_q == ST_CLEAR);
  assign start_screen_en = (state_q == ST_START);
  assign game_over_en    = (state_q == ST_GAME_OVER);
  assign pause_en        = (state_q == ST_PAUSE);
  assign blink           = blink_q | ~blink_state;
  assign RGBout          = rgb_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenarios plus randomized traffic, every clock
// compared against a frame-counting behavioural model of the game flow.
module tb_screen_sequencer;

  localparam int BF = 3;
  localparam int GH = 5;
  localparam int DB = 2;

  localparam int S_START = 0, S_CLEAR = 1, S_PLAY = 2, S_PAUSE = 3, S_GO = 4;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, gameEnded, key_start, key_pause;
  logic        start_screen_dr, game_over_dr;
  logic [11:0] start_screen_RGB, game_over_RGB, game_RGB, RGBout;
  logic        game_enable, new_game, start_screen_en, game_over_en, pause_en, blink;

  always #5 clk = ~clk;

  screen_sequencer #(.BLINK_FRAMES(BF), .GO_HOLD_FRAMES(GH), .DEBOUNCE_FRAMES(DB)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameEnded(gameEnded),
    .key_start(key_start), .key_pause(key_pause),
    .start_screen_dr(start_screen_dr), .start_screen_RGB(start_screen_RGB),
    .game_over_dr(game_over_dr), .game_over_RGB(game_over_RGB), .game_RGB(game_RGB),
    .game_enable(game_enable), .new_game(new_game), .start_screen_en(start_screen_en),
    .game_over_en(game_over_en), .pause_en(pause_en), .blink(blink), .RGBout(RGBout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: state, consecutive-high sample runs per key, frames seen since entering the state.
  int          m_st = S_START;
  int          m_run_s = 0, m_run_p = 0, m_frames = 0;
  logic [11:0] m_rgb = 12'h000;

  function automatic logic model_blink();
    if (m_st == S_START || m_st == S_GO) return ((m_frames / BF) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit ps, pp;
    int nst;
    if (reset) begin
      m_st = S_START; m_run_s = 0; m_run_p = 0; m_frames = 0; m_rgb = 12'h000;
      return;
    end
    case (m_st)
      S_START: m_rgb = start_screen_dr ? start_screen_RGB : 12'h000;
      S_GO:    m_rgb = (game_over_dr && model_blink()) ? game_over_RGB : game_RGB;
      default: m_rgb = game_RGB;
    endcase
    ps = 0; pp = 0;
    if (startOfFrame) begin
      m_run_s = key_start ? m_run_s + 1 : 0;
      m_run_p = key_pause ? m_run_p + 1 : 0;
      ps = (m_run_s == DB);
      pp = (m_run_p == DB);
    end
    nst = m_st;
    case (m_st)
      S_START: if (ps) nst = S_CLEAR;
      S_CLEAR: nst = S_PLAY;
      S_PLAY:  if (gameEnded) nst = S_GO; else if (pp) nst = S_PAUSE;
      S_PAUSE: if (pp) nst = S_PLAY;
      S_GO:    if (ps && m_frames >= GH) nst = S_CLEAR;
      default: nst = S_START;
    endcase
    if (nst != m_st) m_frames = 0;
    else if (startOfFrame && (m_st == S_START || m_st == S_GO)) m_frames++;
    m_st = nst;
  endtask

  task automatic compare_all();
    chk("game_enable", game_enable, m_st == S_PLAY);
    chk("new_game", new_game, m_st == S_CLEAR);
    chk("start_screen_en", start_screen_en, m_st == S_START);
    chk("game_over_en", game_over_en, m_st == S_GO);
    chk("pause_en", pause_en, m_st == S_PAUSE);
    chk("blink", blink, model_blink());
    chk("RGBout", RGBout, m_rgb);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int exp_blink[6] = '{1, 1, 0, 0, 0, 1};

  initial begin
    reset = 1'b1; startOfFrame = 0; gameEnded = 0; key_start = 0; key_pause = 0;
    start_screen_dr = 0; game_over_dr = 0;
    start_screen_RGB = 12'h1A5; game_over_RGB = 12'hF0F; game_RGB = 12'h3C3;
    step(); step();
    chk("rst_start_en", start_screen_en, 1);
    chk("rst_rgb", RGBout, 12'h000);
    reset = 1'b0;

    // 1: start press -> CLEAR -> PLAY
    key_start = 1; frames(2); key_start = 0; frames(1);
    chk("sc1_play", game_enable, 1);

    // 2: short pause press ignored, full press toggles PAUSE both ways
    key_pause = 1; frames(1); key_pause = 0; frames(1);
    chk("sc2_no_pause", pause_en, 0);
    key_pause = 1; frames(2); key_pause = 0; frames(1);
    chk("sc2_pause", pause_en, 1);
    key_pause = 1; frames(2); key_pause = 0; frames(1);
    chk("sc2_resume", game_enable, 1);

    // 3: gameEnded beats a pause press on the same clock
    key_pause = 1; frames(1); gameEnded = 1; frames(1); key_pause = 0; gameEnded = 0; frames(1);
    chk("sc3_go", game_over_en, 1);

    // 4: early start press discarded, held key not re-used, later press accepted
    game_over_dr = 1;
    key_start = 1; frames(6);
    chk("sc4_hold", game_over_en, 1);
    key_start = 0; frames(1);
    key_start = 1; frames(2); key_start = 0; frames(1);
    chk("sc4_play", game_enable, 1);
    game_over_dr = 0;

    // 5: blink in START and start overlay RGB
    do_reset();
    for (int k = 0; k < 6; k++) begin
      startOfFrame = 1; step();
      chk("sc5_blink", blink, exp_blink[k]);
      startOfFrame = 0; step(); step();
    end
    start_screen_dr = 1; start_screen_RGB = 12'hABC; step();
    chk("sc5_rgb_dr", RGBout, 12'hABC);
    start_screen_dr = 0; step();
    chk("sc5_rgb_black", RGBout, 12'h000);

    // 6: mid-frame reset from PAUSE and from GAME_OVER
    key_start = 1; frames(2); key_start = 0; frames(1);
    key_pause = 1; frames(2); key_pause = 0; frames(1);
    startOfFrame = 1; step(); startOfFrame = 0; step();
    do_reset();
    chk("sc6_pause_rst", start_screen_en, 1);
    chk("sc6_pause_ng", new_game, 0);
    key_start = 1; frames(2); key_start = 0; frames(1);
    gameEnded = 1; frames(1); gameEnded = 0; frames(2);
    step();
    do_reset();
    chk("sc6_go_rst", game_over_en, 0);
    chk("sc6_go_blink", blink, 1);

    // randomized traffic
    begin
      int gap = 0;
      for (int c = 0; c < 3000; c++) begin
        startOfFrame = (gap == 0);
        gap = (gap == 0) ? $urandom_range(2, 5) : gap - 1;
        if ($urandom_range(0, 5) == 0) key_start = ~key_start;
        if ($urandom_range(0, 5) == 0) key_pause = ~key_pause;
        gameEnded        = ($urandom_range(0, 40) == 0);
        start_screen_dr  = $urandom_range(0, 1);
        game_over_dr     = $urandom_range(0, 1);
        start_screen_RGB = 12'($urandom);
        game_over_RGB    = 12'($urandom);
        game_RGB         = 12'($urandom);
        reset            = ($urandom_range(0, 400) == 0);
        step();
      end
      reset = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
